// File: rtl/pressure_alarm_debounce.sv
// pressure_alarm_debounce: hysteresis comparator with a debounced alarm FSM.
// Samples arrive over valid/ready; each accepted sample is evaluated once.
// Optional build macro PRESS_AVG_EN: compare a 4-sample moving average
// instead of the raw sample, which adds one pipeline cycle.
module pressure_alarm_debounce #(
   parameter int DATA_W    = 12,
   parameter int HI_THRESH = 3000,
   parameter int LO_THRESH = 2500,
   parameter int DEBOUNCE  = 4,
   parameter int CNT_W     = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] sample,
   output logic              sample_ready,
   output logic              alarm,
   output logic              alarm_rise,
   output logic              alarm_fall,
   output logic [1:0]        state,
   output logic [CNT_W-1:0]  deb_cnt
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RISE_PEND = 2'd1,
      ALARM     = 2'd2,
      FALL_PEND = 2'd3
   } state_t;

   localparam logic [DATA_W-1:0] HI      = DATA_W'(HI_THRESH);
   localparam logic [DATA_W-1:0] LO      = DATA_W'(LO_THRESH);
   localparam logic [CNT_W-1:0]  DEB_MAX = CNT_W'(DEBOUNCE);

   if (LO_THRESH >= HI_THRESH) begin : g_bad_thresh
      $error("pressure_alarm_debounce: LO_THRESH must be below HI_THRESH");
   end
   if (DEBOUNCE < 1) begin : g_bad_debounce
      $error("pressure_alarm_debounce: DEBOUNCE must be at least 1");
   end
   if ((1 << CNT_W) <= DEBOUNCE) begin : g_bad_cnt_w
      $error("pressure_alarm_debounce: CNT_W too narrow for DEBOUNCE");
   end

   logic   accept;
   logic   eval_q;     // compare flags valid: FSM steps on the next edge
   logic   over_q;
   logic   under_q;
   state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic   rise_q, rise_d, fall_q, fall_d;

   assign accept = sample_valid & sample_ready;

`ifdef PRESS_AVG_EN
   logic [DATA_W-1:0] win0, win1, win2, win3;
   logic [DATA_W+1:0] sum;
   logic [DATA_W-1:0] avg;
   logic              avg_pend;   // window updated, average computed next edge

   // Sum of the four most recent accepted samples, divided by four
   always_comb begin
      sum = {2'b00, win0} + {2'b00, win1} + {2'b00, win2} + {2'b00, win3};
      avg = sum[DATA_W+1:2];
   end

   // Shift accepted samples into the averaging window
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         win0     <= '0;
         win1     <= '0;
         win2     <= '0;
         win3     <= '0;
         avg_pend <= 1'b0;
      end else begin
         avg_pend <= accept;
         if (accept) begin
            win0 <= sample;
            win1 <= win0;
            win2 <= win1;
            win3 <= win2;
         end
      end
   end

   // Register the threshold compare of the window average
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         eval_q  <= 1'b0;
         over_q  <= 1'b0;
         under_q <= 1'b0;
      end else begin
         eval_q <= avg_pend;
         if (avg_pend) begin
            over_q  <= avg > HI;
            under_q <= avg < LO;
         end
      end
   end

   assign sample_ready = ~(avg_pend | eval_q);
`else
   // Register the threshold compare of the raw accepted sample
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         eval_q  <= 1'b0;
         over_q  <= 1'b0;
         under_q <= 1'b0;
      end else begin
         eval_q <= accept;
         if (accept) begin
            over_q  <= sample > HI;
            under_q <= sample < LO;
         end
      end
   end

   assign sample_ready = ~eval_q;
`endif

   assign cnt_inc = cnt_q + CNT_W'(1);

   // Debounce FSM next-state, counter and edge pulses
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (eval_q) begin
         case (state_q)
            IDLE: begin
               if (over_q) begin
                  if (DEB_MAX == CNT_W'(1)) begin
                     state_d = ALARM;
                     cnt_d   = '0;
                     rise_d  = 1'b1;
                  end else begin
                     state_d = RISE_PEND;
                     cnt_d   = CNT_W'(1);
                  end
               end else begin
                  cnt_d = '0;
               end
            end
            RISE_PEND: begin
               if (over_q) begin
                  if (cnt_inc == DEB_MAX) begin
                     state_d = ALARM;
                     cnt_d   = '0;
                     rise_d  = 1'b1;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end else begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end
            ALARM: begin
               if (under_q) begin
                  if (DEB_MAX == CNT_W'(1)) begin
                     state_d = IDLE;
                     cnt_d   = '0;
                     fall_d  = 1'b1;
                  end else begin
                     state_d = FALL_PEND;
                     cnt_d   = CNT_W'(1);
                  end
               end else begin
                  cnt_d = '0;
               end
            end
            FALL_PEND: begin
               if (under_q) begin
                  if (cnt_inc == DEB_MAX) begin
                     state_d = IDLE;
                     cnt_d   = '0;
                     fall_d  = 1'b1;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end else begin
                  state_d = ALARM;
                  cnt_d   = '0;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // FSM state, counter and pulse registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign alarm      = (state_q == ALARM) || (state_q == FALL_PEND);
   assign alarm_rise = rise_q;
   assign alarm_fall = fall_q;
   assign state      = state_q;
   assign deb_cnt    = cnt_q;

endmodule

// File: tb/tb_pressure_alarm_debounce.sv
// Directed testbench for pressure_alarm_debounce (default parameters).
module tb_pressure_alarm_debounce;

`ifdef PRESS_AVG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        sample_valid = 1'b0;
   logic [11:0] sample = '0;
   logic        sample_ready;
   logic        alarm, alarm_rise, alarm_fall;
   logic [1:0]  state;
   logic [2:0]  deb_cnt;

   int checks = 0;
   int errors = 0;
   int rise_seen = 0;
   int fall_seen = 0;

   pressure_alarm_debounce dut (
      .clk          (clk),
      .reset        (reset),
      .sample_valid (sample_valid),
      .sample       (sample),
      .sample_ready (sample_ready),
      .alarm        (alarm),
      .alarm_rise   (alarm_rise),
      .alarm_fall   (alarm_fall),
      .state        (state),
      .deb_cnt      (deb_cnt)
   );

   always #5 clk = ~clk;

   // Count pulses away from the active edge
   always @(negedge clk) begin
      if (alarm_rise) rise_seen++;
      if (alarm_fall) fall_seen++;
   end

   // {state, deb_cnt, alarm, alarm_rise, alarm_fall}
   function automatic logic [7:0] obs();
      return {state, deb_cnt, alarm, alarm_rise, alarm_fall};
   endfunction

   task automatic do_reset();
      sample_valid = 1'b0;
      @(negedge clk) reset = 1'b0;
      @(negedge clk) reset = 1'b1;
   endtask

   // Offer one sample, wait for accept, then wait until outputs reflect it
   task automatic send(input logic [11:0] v);
      int w;
      w = 0;
      @(negedge clk);
      while (!sample_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (!sample_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout ready=%0b required 1", sample_ready);
      end
      sample = v;
      sample_valid = 1'b1;
      @(posedge clk);
      #1 sample_valid = 1'b0;
      repeat (LAT) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [7:0] exp;
      do_reset();
      #1;
      checks++;
      if (obs() !== 8'b00_000_000 || sample_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_values got %b rdy %b want 00000000 rdy 1", obs(), sample_ready);
      end
`ifdef PRESS_AVG_EN
      for (int i = 0; i < 5; i++) send(12'd4000);
`else
      for (int i = 0; i < 2; i++) send(12'd3001);
`endif
      exp = {2'd1, 3'd2, 3'b000};
      checks++;
      if (obs() !== exp) begin
         errors++;
         $display("FAIL reset_prime got %b want %b", obs(), exp);
      end
      #3 reset = 1'b0;
      #1;
      checks++;
      if (obs() !== 8'b00_000_000 || sample_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_async got %b rdy %b want 00000000 rdy 1", obs(), sample_ready);
      end
      @(negedge clk) reset = 1'b1;
   endtask

   task automatic test_rise();
      logic [7:0] exp;
      int r0;
      do_reset();
      r0 = rise_seen;
      for (int i = 1; i <= 3; i++) begin
         send(12'd3001);
         exp = {2'd1, 3'(i), 3'b000};
         checks++;
         if (obs() !== exp) begin
            errors++;
            $display("FAIL rise_pend%0d got %b want %b", i, obs(), exp);
         end
      end
      send(12'd3001);
      exp = {2'd2, 3'd0, 3'b110};
      checks++;
      if (obs() !== exp) begin
         errors++;
         $display("FAIL rise_assert got %b want %b", obs(), exp);
      end
      @(posedge clk);
      #1;
      exp = {2'd2, 3'd0, 3'b100};
      checks++;
      if (obs() !== exp) begin
         errors++;
         $display("FAIL rise_pulse_end got %b want %b", obs(), exp);
      end
      checks++;
      if (rise_seen - r0 !== 1) begin
         errors++;
         $display("FAIL rise_pulse_count got %0d want 1", rise_seen - r0);
      end
      do_reset();
      for (int i = 0; i < 3; i++) send(12'd3001);
      send(12'd2999);
      exp = {2'd0, 3'd0, 3'b000};
      checks++;
      if (obs() !== exp) begin
         errors++;
         $display("FAIL rise_abort got %b want %b", obs(), exp);
      end
   endtask

   task automatic test_hysteresis();
      logic [7:0] exp;
      logic [11:0] band [3];
      int f0;
      band[0] = 12'd2500;
      band[1] = 12'd2700;
      band[2] = 12'd3000;
      do_reset();
      for (int i = 0; i < 4; i++) send(12'd3001);
      for (int i = 0; i < 3; i++) begin
         send(band[i]);
         exp = {2'd2, 3'd0, 3'b100};
         checks++;
         if (obs() !== exp) begin
            errors++;
            $display("FAIL hyst_band%0d got %b want %b", i, obs(), exp);
         end
      end
      f0 = fall_seen;
      for (int i = 1; i <= 3; i++) begin
         send(12'd2499);
         exp = {2'd3, 3'(i), 3'b100};
         checks++;
         if (obs() !== exp) begin
            errors++;
            $display("FAIL fall_pend%0d got %b want %b", i, obs(), exp);
         end
      end
      send(12'd2499);
      exp = {2'd0, 3'd0, 3'b001};
      checks++;
      if (obs() !== exp) begin
         errors++;
         $display("FAIL fall_clear got %b want %b", obs(), exp);
      end
      @(posedge clk);
      #1;
      checks++;
      if (fall_seen - f0 !== 1 || alarm_fall !== 1'b0) begin
         errors++;
         $display("FAIL fall_pulse count %0d now %b want 1 and 0", fall_seen - f0, alarm_fall);
      end
   endtask

   task automatic test_boundary();
      logic [7:0] exp;
      int r0;
      do_reset();
      r0 = rise_seen;
      for (int i = 0; i < 6; i++) send(12'd3000);
      exp = {2'd0, 3'd0, 3'b000};
      checks++;
      if (obs() !== exp || rise_seen != r0) begin
         errors++;
         $display("FAIL bound_hi got %b rises %0d want %b rises 0", obs(), rise_seen - r0, exp);
      end
      for (int i = 0; i < 4; i++) send(12'd3001);
      for (int i = 0; i < 6; i++) send(12'd2500);
      exp = {2'd2, 3'd0, 3'b100};
      checks++;
      if (obs() !== exp) begin
         errors++;
         $display("FAIL bound_lo got %b want %b", obs(), exp);
      end
      send(12'd2499);
      send(12'd2499);
      send(12'd2600);
      checks++;
      if (obs() !== exp) begin
         errors++;
         $display("FAIL fall_abort got %b want %b", obs(), exp);
      end
   endtask

   task automatic test_handshake();
      int n;
      do_reset();
      @(posedge clk);
      #1;
      sample = 12'd2000;
      sample_valid = 1'b1;
      n = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (sample_ready) n++;
      end
      @(posedge clk);
      #1 sample_valid = 1'b0;
      checks++;
      if (n !== 12 / (LAT + 1)) begin
         errors++;
         $display("FAIL hs_rate got %0d want %0d", n, 12 / (LAT + 1));
      end
`ifndef PRESS_AVG_EN
      do_reset();
      @(posedge clk);
      #1;
      sample = 12'd3001;
      sample_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1 sample_valid = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (obs() !== {2'd1, 3'd2, 3'b000}) begin
         errors++;
         $display("FAIL hs_hold got %b want 01010000", obs());
      end
`endif
   endtask

`ifdef PRESS_AVG_EN
   task automatic test_avg();
      logic [7:0] exp;
      int r0;
      do_reset();
      r0 = rise_seen;
      for (int i = 0; i < 8; i++) send((i % 2 == 0) ? 12'd4000 : 12'd0);
      checks++;
      if (alarm !== 1'b0 || rise_seen != r0) begin
         errors++;
         $display("FAIL avg_alt alarm %b rises %0d want 0 0", alarm, rise_seen - r0);
      end
      do_reset();
      // averages 1000, 2000, 3000, 4000, 4000, 4000, 4000
      for (int i = 0; i < 6; i++) send(12'd4000);
      exp = {2'd1, 3'd3, 3'b000};
      checks++;
      if (obs() !== exp) begin
         errors++;
         $display("FAIL avg_pend got %b want %b", obs(), exp);
      end
      send(12'd4000);
      exp = {2'd2, 3'd0, 3'b110};
      checks++;
      if (obs() !== exp) begin
         errors++;
         $display("FAIL avg_rise got %b want %b", obs(), exp);
      end
   endtask
`endif

   initial begin
      test_reset();
`ifdef PRESS_AVG_EN
      test_handshake();
      test_avg();
`else
      test_rise();
      test_hysteresis();
      test_boundary();
      test_handshake();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

endmodule
